// File: rtl/pipeline_dest_tracker_if.sv
// Decode/EX/MEM destination-tracking bundle between the datapath latches and the hazard unit.
// master = datapath/decode side driving decode fields and control; slave = the tracker.
interface pipeline_dest_tracker_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  logic             en;
  logic             flush;
  logic             dec_valid;
  logic [REG_W-1:0] dec_rsel1;
  logic [REG_W-1:0] dec_rsel2;
  logic [REG_W-1:0] dec_wsel;
  logic             dec_regwen;
  logic             stall;
  logic [REG_W-1:0] rsel1_dec;
  logic [REG_W-1:0] rsel2_dec;
  logic [REG_W-1:0] wsel_ex;
  logic [REG_W-1:0] wsel_mem;
  logic             ex_valid;
  logic             mem_valid;
  logic             dec_consume;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output en, flush, dec_valid, dec_rsel1, dec_rsel2, dec_wsel, dec_regwen, stall,
    input  rsel1_dec, rsel2_dec, wsel_ex, wsel_mem, ex_valid, mem_valid,
           dec_consume, stall_count
  );

  modport slave (
    input  en, flush, dec_valid, dec_rsel1, dec_rsel2, dec_wsel, dec_regwen, stall,
    output rsel1_dec, rsel2_dec, wsel_ex, wsel_mem, ex_valid, mem_valid,
           dec_consume, stall_count
  );
endinterface

// File: rtl/pipeline_dest_tracker.sv
// Tracks EX/MEM destination registers for the hazard unit; decode fields reach wsel_ex 1 accepted cycle later, wsel_mem 2.
// A stall holds decode and injects an EX bubble while MEM keeps draining; en=0 freezes everything.
module pipeline_dest_tracker #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input logic                    clk,
  input logic                    rst,
  pipeline_dest_tracker_if.slave pif
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [REG_W-1:0] dwsel;
  logic             bubble;
  logic             count_stall;

  logic             ex_valid_q;
  logic [REG_W-1:0] ex_wsel_q;
  logic             mem_valid_q;
  logic [REG_W-1:0] mem_wsel_q;
  logic [CNT_W-1:0] stall_cnt_q;

  // Register 0 never hazards, so a zero select doubles as "no destination".
  assign dwsel       = (pif.dec_valid & pif.dec_regwen) ? pif.dec_wsel : '0;
  assign bubble      = pif.flush | pif.stall;
  assign count_stall = pif.en & pif.stall & ~pif.flush & pif.dec_valid;

  assign pif.rsel1_dec   = pif.dec_valid ? pif.dec_rsel1 : '0;
  assign pif.rsel2_dec   = pif.dec_valid ? pif.dec_rsel2 : '0;
  assign pif.dec_consume = pif.en & (pif.flush | ~pif.stall);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q  <= 1'b0;
      ex_wsel_q   <= '0;
      mem_valid_q <= 1'b0;
      mem_wsel_q  <= '0;
      stall_cnt_q <= '0;
    end else if (pif.en) begin
      // MEM advances unconditionally so stalls drain without extra cycles.
      mem_valid_q <= ex_valid_q;
      mem_wsel_q  <= ex_wsel_q;
      if (bubble) begin
        ex_valid_q <= 1'b0;
        ex_wsel_q  <= '0;
      end else begin
        ex_valid_q <= pif.dec_valid;
        ex_wsel_q  <= dwsel;
      end
      if (count_stall && (stall_cnt_q != CNT_MAX)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
    end
  end

  assign pif.ex_valid    = ex_valid_q;
  assign pif.mem_valid   = mem_valid_q;
  assign pif.wsel_ex     = ex_wsel_q;
  assign pif.wsel_mem    = mem_wsel_q;
  assign pif.stall_count = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_dest_tracker.sv
// Bench for pipeline_dest_tracker: directed scenarios then random traffic vs a two-stage queue model.
// A second instance with a 2-bit counter shares all inputs to exercise saturation.
module tb_pipeline_dest_tracker;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipeline_dest_tracker_if #(.REG_W(5), .CNT_W(16)) pif ();
  pipeline_dest_tracker_if #(.REG_W(5), .CNT_W(2))  sif ();

  assign sif.en         = pif.en;
  assign sif.flush      = pif.flush;
  assign sif.dec_valid  = pif.dec_valid;
  assign sif.dec_rsel1  = pif.dec_rsel1;
  assign sif.dec_rsel2  = pif.dec_rsel2;
  assign sif.dec_wsel   = pif.dec_wsel;
  assign sif.dec_regwen = pif.dec_regwen;
  assign sif.stall      = pif.stall;

  pipeline_dest_tracker #(.REG_W(5), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .pif (pif.slave)
  );

  pipeline_dest_tracker #(.REG_W(5), .CNT_W(2)) dut_sat (
    .clk (clk),
    .rst (rst),
    .pif (sif.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Reference: in-flight stages as {valid, dest}; index 0 = EX, 1 = MEM.
  typedef struct {
    bit v;
    int w;
  } slot_t;

  slot_t stages[2];
  int    m_cnt;
  int    m_cnt_sat;

  function automatic int sat_inc(input int c, input int maxv);
    return (c >= maxv) ? maxv : c + 1;
  endfunction

  task automatic model_reset();
    stages[0] = '{v: 1'b0, w: 0};
    stages[1] = '{v: 1'b0, w: 0};
    m_cnt     = 0;
    m_cnt_sat = 0;
  endtask

  task automatic check_regs(input string tag);
    check_val({tag, "_ex_valid"},  32'(pif.ex_valid),    32'(stages[0].v));
    check_val({tag, "_wsel_ex"},   32'(pif.wsel_ex),     stages[0].v ? stages[0].w : 0);
    check_val({tag, "_mem_valid"}, 32'(pif.mem_valid),   32'(stages[1].v));
    check_val({tag, "_wsel_mem"},  32'(pif.wsel_mem),    stages[1].v ? stages[1].w : 0);
    check_val({tag, "_cnt"},       32'(pif.stall_count), m_cnt);
    check_val({tag, "_cnt_sat"},   32'(sif.stall_count), m_cnt_sat);
  endtask

  // One clock: drive at negedge, check combinational outputs, advance model at posedge.
  task automatic cycle(input string tag, input bit e, input bit f, input bit dv,
                       input int r1, input int r2, input int w, input bit rw, input bit st);
    slot_t incoming;
    pif.en         = e;
    pif.flush      = f;
    pif.dec_valid  = dv;
    pif.dec_rsel1  = 5'(r1);
    pif.dec_rsel2  = 5'(r2);
    pif.dec_wsel   = 5'(w);
    pif.dec_regwen = rw;
    pif.stall      = st;
    #1;
    check_val({tag, "_rsel1"},   32'(pif.rsel1_dec),   dv ? r1 : 0);
    check_val({tag, "_rsel2"},   32'(pif.rsel2_dec),   dv ? r2 : 0);
    check_val({tag, "_consume"}, 32'(pif.dec_consume), 32'(e && (f || !st)));
    @(posedge clk);
    if (e) begin
      if (f || st) incoming = '{v: 1'b0, w: 0};
      else         incoming = '{v: dv, w: (dv && rw) ? w : 0};
      stages[1] = stages[0];
      stages[0] = incoming;
      if (st && !f && dv) begin
        m_cnt     = sat_inc(m_cnt, 65535);
        m_cnt_sat = sat_inc(m_cnt_sat, 3);
      end
    end
    #1;
    check_regs(tag);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #1;
    check_regs("reset");
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int snap_ex, snap_mem, snap_cnt;
    rst            = 1'b1;
    pif.en         = 1'b0;
    pif.flush      = 1'b0;
    pif.dec_valid  = 1'b0;
    pif.dec_rsel1  = '0;
    pif.dec_rsel2  = '0;
    pif.dec_wsel   = '0;
    pif.dec_regwen = 1'b0;
    pif.stall      = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Basic flow: destination walks EX then MEM.
    cycle("t1a", 1, 0, 1, 1, 2, 5, 1, 0);
    check_val("t1_wsel_ex_5", 32'(pif.wsel_ex), 5);
    cycle("t1b", 1, 0, 1, 3, 4, 6, 1, 0);
    check_val("t1_wsel_mem_5", 32'(pif.wsel_mem), 5);
    check_val("t1_wsel_ex_6", 32'(pif.wsel_ex), 6);

    // Load-use stall: bubble in EX, MEM still drains, decode held.
    cycle("t2a", 1, 0, 1, 0, 0, 7, 1, 0);
    snap_cnt = int'(pif.stall_count);
    cycle("t2b", 1, 0, 1, 7, 0, 8, 1, 1);
    check_val("t2_wsel_ex_bubble", 32'(pif.wsel_ex), 0);
    check_val("t2_wsel_mem_7", 32'(pif.wsel_mem), 7);
    check_val("t2_cnt_plus1", 32'(pif.stall_count), snap_cnt + 1);
    cycle("t2c", 1, 0, 1, 7, 0, 8, 1, 0);
    check_val("t2_wsel_ex_8", 32'(pif.wsel_ex), 8);

    // No-destination cases.
    cycle("t3a", 1, 0, 1, 0, 0, 9, 0, 0);
    check_val("t3_regwen0_wsel", 32'(pif.wsel_ex), 0);
    check_val("t3_regwen0_valid", 32'(pif.ex_valid), 1);
    cycle("t3b", 1, 0, 1, 0, 0, 0, 1, 0);
    check_val("t3_r0_wsel", 32'(pif.wsel_ex), 0);
    cycle("t3c", 1, 0, 0, 0, 0, 9, 1, 0);
    check_val("t3_invalid_valid", 32'(pif.ex_valid), 0);

    // Pipeline frozen while en=0 even with stall asserted.
    cycle("t4p", 1, 0, 1, 0, 0, 11, 1, 0);
    cycle("t4q", 1, 0, 1, 0, 0, 12, 1, 0);
    snap_ex  = int'(pif.wsel_ex);
    snap_mem = int'(pif.wsel_mem);
    snap_cnt = int'(pif.stall_count);
    for (int i = 0; i < 3; i++) begin
      cycle("t4", 0, 0, 1, 0, 0, 13, 1, 1);
      check_val("t4_frozen_ex", 32'(pif.wsel_ex), snap_ex);
      check_val("t4_frozen_mem", 32'(pif.wsel_mem), snap_mem);
      check_val("t4_frozen_cnt", 32'(pif.stall_count), snap_cnt);
    end

    // Flush overrides stall: decode consumed, nothing counted.
    snap_cnt = int'(pif.stall_count);
    cycle("t5", 1, 1, 1, 0, 0, 4, 1, 1);
    check_val("t5_wsel_ex", 32'(pif.wsel_ex), 0);
    check_val("t5_cnt_same", 32'(pif.stall_count), snap_cnt);

    // Saturation of the 2-bit counter, then async reset mid-stall.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cycle("t6", 1, 0, 1, 1, 1, 3, 1, 1);
      check_val("t6_sat_seq", 32'(sif.stall_count), (i < 3) ? i + 1 : 3);
    end
    pif.en    = 1'b1;
    pif.stall = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check_val("t6_rst_cnt", 32'(pif.stall_count), 0);
    check_val("t6_rst_cnt_sat", 32'(sif.stall_count), 0);
    check_val("t6_rst_ex_valid", 32'(pif.ex_valid), 0);
    check_val("t6_rst_mem_valid", 32'(pif.mem_valid), 0);
    check_val("t6_rst_wsel_mem", 32'(pif.wsel_mem), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cycle("rnd",
            ($urandom_range(0, 9) < 8),
            ($urandom_range(0, 9) < 1),
            ($urandom_range(0, 9) < 8),
            int'($urandom_range(0, 31)),
            int'($urandom_range(0, 31)),
            int'($urandom_range(0, 31)),
            ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 9) < 4));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
